// File: rtl/fp_add_arbiter_pkg.sv
// Shared types and constants for the FP adder arbiter: FSM states,
// default FP format widths and the error word returned on timeout.
package fp_add_pkg;

  localparam int EXP_W_DEF = 7;
  localparam int MAN_W_DEF = 24;
  localparam int W_DEF     = EXP_W_DEF + MAN_W_DEF + 1;

  // Wide enough for any supported format; users slice the low W bits.
  localparam logic [63:0] FP_ERR = '1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_BUSY,
    ST_RESP,
    ST_REARM
  } state_t;

endpackage

// File: rtl/fp_add_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping modulo NUM_REQ.
module rr_arbiter
  import fp_add_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   idx,
  output logic               any
);

  logic [PTR_W-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = PTR_W'((32'(ptr) + i) % NUM_REQ);
      if (!any && req[cand]) begin
        any         = 1'b1;
        idx         = cand;
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp_add_arbiter.sv
// Round-robin sequencer sharing one multi-cycle FP adder between NUM_REQ
// requesters; a watchdog turns a hung add into an error response.
module fp_add_arbiter
  import fp_add_pkg::*;
#(
  parameter int  NUM_REQ = 4,
  parameter int  EXP_W   = EXP_W_DEF,
  parameter int  MAN_W   = MAN_W_DEF,
  parameter int  TIMEOUT = 255,
  localparam int W       = EXP_W + MAN_W + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*W-1:0] req_a,
  input  logic [NUM_REQ*W-1:0] req_b,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   resp_valid,
  output logic [W-1:0]         resp_sum,
  output logic                 resp_err,
  output logic                 busy,
  output logic                 fpu_start,
  output logic [W-1:0]         fpu_a,
  output logic [W-1:0]         fpu_b,
  input  logic [W-1:0]         fpu_s,
  input  logic                 fpu_ready,
  output logic                 fpu_rst_n
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int WD_W  = 16;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  state_t             state, state_nx;
  logic [PTR_W-1:0]   ptr, owner, g_idx;
  logic [NUM_REQ-1:0] g_oh;
  logic               g_any;
  logic [WD_W-1:0]    wd;
  logic               wd_expired;

  assign wd_expired = (wd == WD_LAST);

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (g_oh),
    .idx   (g_idx),
    .any   (g_any)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (g_any) state_nx = ST_LAUNCH;
      ST_LAUNCH: state_nx = ST_BUSY;
      ST_BUSY:   if (fpu_ready || wd_expired) state_nx = ST_RESP;
      ST_RESP:   state_nx = ST_REARM;
      ST_REARM:  state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = '0;
    resp_valid = '0;
    fpu_start  = 1'b0;
    busy       = (state != ST_IDLE);
    case (state)
      ST_IDLE:   req_ready = g_oh;
      ST_LAUNCH: fpu_start = 1'b1;
      ST_RESP:   resp_valid[owner] = 1'b1;
      default:   ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr       <= '0;
      owner     <= '0;
      fpu_a     <= '0;
      fpu_b     <= '0;
      resp_sum  <= '0;
      resp_err  <= 1'b0;
      wd        <= '0;
      fpu_rst_n <= 1'b0;
    end else begin
      // Registered so the adder reset is glitch-free and low exactly during REARM.
      fpu_rst_n <= (state_nx != ST_REARM);
      case (state)
        ST_IDLE: begin
          if (g_any) begin
            owner <= g_idx;
            fpu_a <= req_a[int'(g_idx)*W +: W];
            fpu_b <= req_b[int'(g_idx)*W +: W];
            ptr   <= (g_idx == PTR_W'(NUM_REQ - 1)) ? '0 : g_idx + PTR_W'(1);
          end
        end
        ST_LAUNCH: wd <= '0;
        ST_BUSY: begin
          if (fpu_ready) begin
            resp_sum <= fpu_s;
            resp_err <= 1'b0;
          end else if (wd_expired) begin
            resp_sum <= FP_ERR[W-1:0];
            resp_err <= 1'b1;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Directed bench for fp_add_arbiter with a behavioural multi-cycle adder
// whose ready flag is sticky until its reset, and an optional hang mode.
module tb_fp_add_arbiter;
  import fp_add_pkg::*;

  localparam int N   = 4;
  localparam int W   = W_DEF;
  localparam int LAT = 3;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_a = '0;
  logic [N*W-1:0] req_b = '0;
  logic [N-1:0]   req_ready, resp_valid;
  logic [W-1:0]   resp_sum, fpu_a, fpu_b, fpu_s;
  logic           resp_err, busy, fpu_start, fpu_ready, fpu_rst_n;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  fp_add_arbiter #(
    .NUM_REQ (N),
    .EXP_W   (EXP_W_DEF),
    .MAN_W   (MAN_W_DEF),
    .TIMEOUT (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_sum   (resp_sum),
    .resp_err   (resp_err),
    .busy       (busy),
    .fpu_start  (fpu_start),
    .fpu_a      (fpu_a),
    .fpu_b      (fpu_b),
    .fpu_s      (fpu_s),
    .fpu_ready  (fpu_ready),
    .fpu_rst_n  (fpu_rst_n)
  );

  // Truncating adder for the 1/7/24 format with hidden bit; exponent 0 is zero.
  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    logic sa, sb, st;
    int ea, eb, et, d;
    logic [25:0] ma, mb, mt;
    sa = a[31]; ea = int'(a[30:24]); ma = {2'b01, a[23:0]};
    sb = b[31]; eb = int'(b[30:24]); mb = {2'b01, b[23:0]};
    if (ea == 0) return b;
    if (eb == 0) return a;
    if (ea < eb || (ea == eb && ma < mb)) begin
      st = sa; sa = sb; sb = st;
      et = ea; ea = eb; eb = et;
      mt = ma; ma = mb; mb = mt;
    end
    d  = ea - eb;
    mb = mb >> d;
    if (sa == sb) begin
      mt = ma + mb;
      if (mt[25]) begin mt = mt >> 1; ea++; end
    end else begin
      mt = ma - mb;
      if (mt == '0) return 32'h0;
      while (!mt[24]) begin mt = mt << 1; ea--; end
    end
    return {sa, 7'(ea), mt[23:0]};
  endfunction

  bit           hang = 1'b0;
  bit           active;
  int           cnt;
  logic [W-1:0] opa, opb;

  always @(posedge clk or negedge fpu_rst_n) begin
    if (!fpu_rst_n) begin
      fpu_ready <= 1'b0; fpu_s <= '0; active <= 1'b0; cnt <= 0;
    end else if (fpu_start) begin
      active <= 1'b1; cnt <= LAT; opa <= fpu_a; opb <= fpu_b;
    end else if (active && !hang) begin
      if (cnt == 1) begin
        fpu_ready <= 1'b1; fpu_s <= fadd(opa, opb); active <= 1'b0;
      end else cnt <= cnt - 1;
    end
  end

  // Requester protocol watch: valid held and operands stable until accepted.
  int           proto_viol = 0;
  logic [N-1:0] pend;
  logic [W-1:0] hold_a [N];
  logic [W-1:0] hold_b [N];

  always @(posedge clk or negedge reset) begin
    if (!reset) pend <= '0;
    else begin
      if ($countones(req_ready) > 1) proto_viol <= proto_viol + 1;
      for (int i = 0; i < N; i++) begin
        if (pend[i] && (!req_valid[i] || req_a[i*W +: W] !== hold_a[i] ||
                        req_b[i*W +: W] !== hold_b[i])) begin
          proto_viol <= proto_viol + 1;
          $display("requester %0d broke the request protocol", i);
        end
        pend[i]   <= req_valid[i] && !req_ready[i];
        hold_a[i] <= req_a[i*W +: W];
        hold_b[i] <= req_b[i*W +: W];
      end
    end
  end

  function automatic int oh2i(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  int           j_g, j_lat, j_nstart, j_nready, j_rstlow;
  logic [W-1:0] j_sum;
  logic         j_err;
  logic [N-1:0] j_rv;
  bit           j_to;

  // Single request from requester i; records what the DUT did, checks nothing.
  task automatic do_job(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    int cyc;
    j_g = -1; j_sum = '0; j_err = 1'b0; j_lat = 0; j_nstart = 0;
    j_nready = 0; j_rstlow = 0; j_rv = '0; j_to = 1'b0;
    req_a[i*W +: W] = a; req_b[i*W +: W] = b; req_valid[i] = 1'b1;
    #1; cyc = 0;
    while (req_ready == '0 && cyc < 50) begin @(negedge clk); #1; cyc++; end
    if (req_ready == '0) begin j_to = 1'b1; req_valid[i] = 1'b0; return; end
    j_g = oh2i(req_ready); j_nready = 1;
    @(negedge clk); req_valid[i] = 1'b0; #1; cyc = 0;
    while (resp_valid == '0 && cyc < 60) begin
      if (fpu_start) j_nstart++;
      if (req_ready != '0) j_nready++;
      @(negedge clk); #1; cyc++;
    end
    if (resp_valid == '0) begin j_to = 1'b1; return; end
    j_lat = cyc; j_rv = resp_valid; j_sum = resp_sum; j_err = resp_err;
    repeat (2) begin @(negedge clk); #1; if (!fpu_rst_n) j_rstlow++; end
  endtask

  int           gord [8];
  int           rord [8];
  logic [W-1:0] bsum [8];
  logic         berr [8];
  int           seqbad;
  bit           bto;

  // Requesters in mask hold valid until granted p<i> times; records grant/response order.
  task automatic run_burst(input logic [N-1:0] mask, input int p0, input int p1,
                           input int p2, input int p3, input logic [W-1:0] a,
                           input logic [W-1:0] b, input int total);
    int left [N];
    int ng, nr, cyc, drop, g;
    bit rearm_since;
    left[0] = p0; left[1] = p1; left[2] = p2; left[3] = p3;
    for (int i = 0; i < 8; i++) begin gord[i] = -1; rord[i] = -1; bsum[i] = '0; berr[i] = 1'b0; end
    for (int i = 0; i < N; i++)
      if (mask[i]) begin req_a[i*W +: W] = a; req_b[i*W +: W] = b; req_valid[i] = 1'b1; end
    ng = 0; nr = 0; cyc = 0; drop = -1; seqbad = 0; bto = 1'b0; rearm_since = 1'b1;
    #1;
    while (nr < total && cyc < 400) begin
      if (req_ready != '0) begin
        g = oh2i(req_ready);
        if (!rearm_since) seqbad++;
        rearm_since = 1'b0;
        if (ng < 8) gord[ng] = g;
        ng++;
        left[g]--;
        if (left[g] == 0) drop = g;
      end
      if (resp_valid != '0) begin
        if (nr < 8) begin rord[nr] = oh2i(resp_valid); bsum[nr] = resp_sum; berr[nr] = resp_err; end
        nr++;
      end
      if (!fpu_rst_n) rearm_since = 1'b1;
      @(negedge clk);
      if (drop >= 0) begin req_valid[drop] = 1'b0; drop = -1; end
      #1; cyc++;
    end
    if (nr < total) bto = 1'b1;
    req_valid = '0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1;
    checks++; if ({busy, fpu_start, resp_err, fpu_rst_n} !== 4'b0) begin fails++;
      $display("FAIL reset_ctrl: got %b, want 0000", {busy, fpu_start, resp_err, fpu_rst_n}); end
    checks++; if ({req_ready, resp_valid} !== '0) begin fails++;
      $display("FAIL reset_pulses: got %b, want 0", {req_ready, resp_valid}); end
    checks++; if ({resp_sum, fpu_a, fpu_b} !== '0) begin fails++;
      $display("FAIL reset_data: got %h %h %h, want zeros", resp_sum, fpu_a, fpu_b); end
    @(negedge clk); reset = 1'b1; #1;
    checks++; if (fpu_rst_n !== 1'b0) begin fails++;
      $display("FAIL rst_n_before_edge: got %b, want 0", fpu_rst_n); end
    @(negedge clk); #1;
    checks++; if ({fpu_rst_n, busy} !== 2'b10) begin fails++;
      $display("FAIL rst_n_release: got %b, want 10", {fpu_rst_n, busy}); end
  endtask

  task automatic test_round_robin();
    run_burst(4'b1111, 2, 1, 1, 1, 32'h3F000000, 32'h0, 5);
    checks++; if (bto !== 1'b0) begin fails++; $display("FAIL rr_timeout: got %b, want 0", bto); end
    for (int k = 0; k < 5; k++) begin
      checks++; if (gord[k] !== k % 4) begin fails++;
        $display("FAIL rr_grant[%0d]: got %0d, want %0d", k, gord[k], k % 4); end
      checks++; if (rord[k] !== k % 4 || bsum[k] !== 32'h3F000000 || berr[k] !== 1'b0) begin fails++;
        $display("FAIL rr_resp[%0d]: got owner %0d sum %h err %b, want %0d 3f000000 0",
                 k, rord[k], bsum[k], berr[k], k % 4); end
    end
    checks++; if (seqbad !== 0) begin fails++;
      $display("FAIL rr_rearm_between: got %0d grants without REARM, want 0", seqbad); end
  endtask

  task automatic test_pointer_wrap();
    do_job(3, 32'h3F000000, 32'h0);
    checks++; if (j_g !== 3 || j_to) begin fails++;
      $display("FAIL wrap_grant3: got %0d (to=%b), want 3", j_g, j_to); end
    run_burst(4'b0110, 0, 1, 1, 0, 32'h3F000000, 32'h0, 2);
    checks++; if (gord[0] !== 1 || gord[1] !== 2 || bto) begin fails++;
      $display("FAIL wrap_order: got %0d,%0d (to=%b), want 1,2", gord[0], gord[1], bto); end
  endtask

  task automatic test_single_job();
    do_job(0, 32'h3F800000, 32'hBF000000);
    checks++; if (j_g !== 0 || j_nready !== 1 || j_to) begin fails++;
      $display("FAIL single_accept: got grant %0d pulses %0d, want 0 and 1", j_g, j_nready); end
    checks++; if (j_nstart !== 1) begin fails++;
      $display("FAIL single_start: got %0d pulses, want 1", j_nstart); end
    checks++; if (j_rv !== 4'b0001 || j_sum !== 32'h3E000000 || j_err !== 1'b0) begin fails++;
      $display("FAIL single_resp: got %b %h %b, want 0001 3e000000 0", j_rv, j_sum, j_err); end
    checks++; if (j_lat !== 5) begin fails++;
      $display("FAIL single_latency: got %0d, want 5", j_lat); end
    checks++; if (j_rstlow !== 1) begin fails++;
      $display("FAIL single_rearm: got %0d low cycles, want 1", j_rstlow); end
  endtask

  task automatic test_timeout();
    hang = 1'b1;
    do_job(1, 32'h3F800000, 32'h3F800000);
    hang = 1'b0;
    checks++; if (j_rv !== 4'b0010 || j_sum !== 32'hFFFFFFFF || j_err !== 1'b1) begin fails++;
      $display("FAIL timeout_resp: got %b %h %b, want 0010 ffffffff 1", j_rv, j_sum, j_err); end
    checks++; if (j_lat !== 9) begin fails++;
      $display("FAIL timeout_latency: got %0d, want 9", j_lat); end
    do_job(1, 32'h3F800000, 32'h3F800000);
    checks++; if (j_sum !== 32'h40800000 || j_err !== 1'b0 || j_lat !== 5) begin fails++;
      $display("FAIL after_timeout: got %h %b lat %0d, want 40800000 0 5", j_sum, j_err, j_lat); end
  endtask

  task automatic test_back_to_back();
    do_job(2, 32'h3F800000, 32'h3F000000);
    checks++; if (j_sum !== 32'h40400000 || j_lat !== 5 || j_rv !== 4'b0100) begin fails++;
      $display("FAIL b2b_first: got %h lat %0d rv %b, want 40400000 5 0100", j_sum, j_lat, j_rv); end
    do_job(2, 32'h40000000, 32'hBF000000);
    checks++; if (j_lat !== 5) begin fails++;
      $display("FAIL b2b_sticky_latency: got %0d, want 5", j_lat); end
    checks++; if (j_sum !== 32'h3F000000 || j_err !== 1'b0) begin fails++;
      $display("FAIL b2b_second: got %h %b, want 3f000000 0", j_sum, j_err); end
  endtask

  task automatic test_reset_mid_busy();
    int rv_seen, rst_high;
    req_a[2*W +: W] = 32'h3F800000; req_b[2*W +: W] = 32'h3F000000; req_valid[2] = 1'b1;
    #1;
    for (int c = 0; c < 20 && req_ready == '0; c++) begin @(negedge clk); #1; end
    @(negedge clk); req_valid[2] = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0; #1;
    checks++; if ({busy, fpu_start, resp_err, fpu_rst_n, req_ready, resp_valid} !== '0) begin fails++;
      $display("FAIL midreset_ctrl: got busy %b start %b err %b rst_n %b rdy %b rv %b, want zeros",
               busy, fpu_start, resp_err, fpu_rst_n, req_ready, resp_valid); end
    checks++; if ({resp_sum, fpu_a, fpu_b} !== '0) begin fails++;
      $display("FAIL midreset_data: got %h %h %h, want zeros", resp_sum, fpu_a, fpu_b); end
    rv_seen = 0; rst_high = 0;
    repeat (4) begin
      @(negedge clk); #1;
      if (resp_valid != '0) rv_seen++;
      if (fpu_rst_n) rst_high++;
    end
    checks++; if (rv_seen !== 0 || rst_high !== 0) begin fails++;
      $display("FAIL midreset_quiet: got %0d responses %0d rst_n high, want 0 0", rv_seen, rst_high); end
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    run_burst(4'b1001, 1, 0, 0, 1, 32'h3F800000, 32'hBF000000, 2);
    checks++; if (gord[0] !== 0 || gord[1] !== 3 || bto) begin fails++;
      $display("FAIL midreset_ptr: got %0d,%0d (to=%b), want 0,3", gord[0], gord[1], bto); end
    checks++; if (bsum[0] !== 32'h3E000000 || bsum[1] !== 32'h3E000000 || berr[0] || berr[1]) begin fails++;
      $display("FAIL midreset_resume: got %h %h, want 3e000000 twice", bsum[0], bsum[1]); end
  endtask

  task automatic test_protocol();
    checks++; if (proto_viol !== 0) begin fails++;
      $display("FAIL protocol: got %0d violations, want 0", proto_viol); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_pointer_wrap();
    test_single_job();
    test_timeout();
    test_back_to_back();
    test_reset_mid_busy();
    repeat (3) @(negedge clk);
    test_protocol();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit: simulation still running at %0t", $time);
    $fatal(1);
  end

endmodule

// File: doc/fp_add_arbiter.md
Name: fp_add_arbiter

Overview:
Round-robin arbiter and sequencer that shares one multi-cycle floating-point adder between NUM_REQ requesters. For each job it accepts one operand pair, drives the adder's start/operand inputs and waits for the adder's ready. It then returns the sum to the owning requester and re-arms the adder, whose ready flag is sticky. A watchdog converts a hung adder operation into an error response.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
EXP_W, 7, exponent width of the FP format
MAN_W, 24, stored mantissa width; word width W = EXP_W+MAN_W+1 (sign at MSB, then exponent, then mantissa)
TIMEOUT, 255, maximum BUSY cycles before an error response (1..2^16-1)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
req_valid  in  NUM_REQ  per-requester request; must stay high with stable operands until accepted
req_a  in  NUM_REQ*W  operand A, requester i at slice [i*W +: W]
req_b  in  NUM_REQ*W  operand B, same packing
req_ready  out  NUM_REQ  one-hot, one-cycle accept pulse
resp_valid  out  NUM_REQ  one-hot, one-cycle response pulse to the owner; no backpressure
resp_sum  out  W  result; valid when any resp_valid bit is high, otherwise holds its last value
resp_err  out  1  high with resp_valid when the job timed out
busy  out  1  high in every state except IDLE
fpu_start  out  1  adder start
fpu_a, fpu_b  out  W  adder operands
fpu_s  in  W  adder sum
fpu_ready  in  1  adder completion; level, sticky until adder reset
fpu_rst_n  out  1  registered active-low reset to the adder

Behaviour:
- Reset (reset low, async): state IDLE; rr pointer 0; req_ready, resp_valid, fpu_start, resp_err and busy at 0; resp_sum, fpu_a and fpu_b at 0; fpu_rst_n at 0, so the adder is held in reset. fpu_rst_n goes to 1 at the first clk edge after reset is released.
- FSM states: IDLE, LAUNCH, BUSY, RESP, REARM.
- IDLE: if any req_valid is set, grant the first set index at or after the pointer, wrapping modulo NUM_REQ. In the same cycle, pulse req_ready[g] (combinational from state and grant), latch g as owner, register req_a/req_b[g] into fpu_a/fpu_b, set pointer = (g+1) mod NUM_REQ, and go to LAUNCH. Otherwise stay in IDLE.
- LAUNCH: fpu_start = 1 for exactly this cycle; clear the watchdog; go to BUSY.
- BUSY: fpu_a and fpu_b are held stable. If fpu_ready = 1, capture fpu_s into resp_sum, set resp_err = 0 and go to RESP. Else, if the watchdog equals TIMEOUT-1, set resp_sum = all ones, resp_err = 1 and go to RESP. Else increment the watchdog.
- RESP: resp_valid[owner] = 1 for one cycle; go to REARM.
- REARM: fpu_rst_n = 0 for one cycle, clearing the sticky ready; go to IDLE. The IDLE cycle guarantees at least one full cycle of adder reset release before the next start.
- Overhead per job: 4 cycles plus adder latency; at most one job is in flight.
- Fairness: with all requesters valid continuously, grants rotate 0,1,2,3,0,... Requests that arrive during a job are simply not granted until IDLE.
- Requester protocol violations (dropping valid before accept, changing operands) are undefined behaviour and are flagged by bench assertions.
- fpu_ready high during IDLE/LAUNCH is ignored. It cannot occur after REARM.
- A reset mid-operation aborts the job; no response is issued for it.

Decomposition:
- Package fp_add_pkg: state enum, default EXP_W/MAN_W, derived word width W, and the error constant FP_ERR (all ones).
- One sub-module, rr_arbiter: combinational round-robin selection. Inputs: request vector and pointer. Outputs: one-hot grant, binary index and an any-request flag. The FSM, watchdog and datapath stay in fp_add_arbiter.

Test Plan:
- Single job, real adder: requester 0 with a=0x3F800000 (1.5), b=0xBF000000 (-1.0) -> req_ready[0] one pulse; fpu_start one pulse; then resp_valid[0] pulse with resp_sum=0x3E000000 and resp_err=0; fpu_rst_n low for exactly one cycle.
- Round robin: all four requesters valid from reset, each with a=0x3F000000 and b=0 -> grants in order 0,1,2,3,0; every resp_sum=0x3F000000; no two grants without an intervening REARM.
- Pointer wrap: after a grant to 3, raise requests 1 and 2 together -> 1 is granted first (pointer=0), then 2.
- Timeout: use an adder stub that never asserts ready, with TIMEOUT=8 -> resp_valid pulses 8 BUSY cycles after LAUNCH with resp_sum=0xFFFFFFFF and resp_err=1; the next job completes normally.
- Sticky ready: two back-to-back jobs on requester 2 -> the second response waits for a fresh fpu_ready and is never returned in the cycle after LAUNCH.
- Reset mid-BUSY: assert reset -> all outputs at reset values immediately; no resp_valid; pointer 0; fpu_rst_n 0; after release a new job completes correctly.
